counter_read_latch: RTL and testbench

//  CPU read path for one 8254 counter: the reader counterpart of the control-word/count write path.

---
 rtl/counter_read_latch_if.sv | 22 ++
 rtl/counter_read_latch.sv | 154 +++++++++++++++
 tb/tb_counter_read_latch.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_read_latch_if.sv
// CPU-side bus of one 8254 counter read path: command/read strobes in, read data and latch flags out.
`timescale 1ns/1ps
interface counter_read_latch_if;
  logic       cw_write;
  logic       latch_cmd;
  logic       rb_count;
  logic       rb_status;
  logic       rd_strobe;
  logic [7:0] data_out;
  logic       count_latched;
  logic       status_latched;

  modport master (
    output cw_write, latch_cmd, rb_count, rb_status, rd_strobe,
    input  data_out, count_latched, status_latched
  );

  modport slave (
    input  cw_write, latch_cmd, rb_count, rb_status, rd_strobe,
    output data_out, count_latched, status_latched
  );
endinterface

// File: rtl/counter_read_latch.sv
// 8254 counter read path: output latch, status latch and RW-mode byte sequencing.
// Define READBACK_EN to enable the read-back command (rb_count / rb_status and the status latch).
`timescale 1ns/1ps
module counter_read_latch #(
  parameter int unsigned COUNT_W   = 16,
  parameter logic [7:0]  IDLE_DATA = 8'h00
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [5:0]         control_word,
  input  logic [COUNT_W-1:0] count_value,
  input  logic               OUT,
  input  logic               null_count,
  counter_read_latch_if.slave bus
);

  localparam int unsigned NBYTES = COUNT_W / 8;

  typedef enum logic {
    PTR_LSB = 1'b0,
    PTR_MSB = 1'b1
  } byte_ptr_t;

  byte_ptr_t          ptr_reg, ptr_next;
  logic [COUNT_W-1:0] ol_reg, ol_next;
  logic               count_latched_reg, count_latched_next;
  logic [7:0]         data_out_reg, data_out_next;
  logic [7:0]         ol_byte [NBYTES];
  logic [1:0]         rw;
  logic               latch_req;
  logic               status_read;
  logic               read_clears;
  logic               status_latched_q;
  logic [7:0]         status_byte_q;

  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_ol_byte
      assign ol_byte[gi] = ol_reg[8*gi +: 8];
    end
  endgenerate

  assign rw          = control_word[5:4];
  assign status_read = bus.rd_strobe & status_latched_q;

`ifdef READBACK_EN
  logic       status_latched_reg, status_latched_next;
  logic [7:0] status_byte_reg, status_byte_next;

  assign latch_req = bus.latch_cmd | bus.rb_count;

  // A pending status byte is consumed by the read before a new rb_status can latch again.
  always_comb begin
    status_latched_next = status_latched_reg;
    status_byte_next    = status_byte_reg;
    if (bus.cw_write) begin
      status_latched_next = 1'b0;
    end else if (status_read) begin
      status_latched_next = 1'b0;
    end else if (bus.rb_status && !status_latched_reg) begin
      status_byte_next    = {OUT, null_count, control_word};
      status_latched_next = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      status_latched_reg <= 1'b0;
      status_byte_reg    <= 8'h00;
    end else begin
      status_latched_reg <= status_latched_next;
      status_byte_reg    <= status_byte_next;
    end
  end

  assign status_latched_q = status_latched_reg;
  assign status_byte_q    = status_byte_reg;
`else
  logic unused_readback;

  assign unused_readback  = ^{bus.rb_count, bus.rb_status, OUT, null_count};
  assign latch_req        = bus.latch_cmd;
  assign status_latched_q = 1'b0;
  assign status_byte_q    = IDLE_DATA;
`endif

  always_comb begin
    ptr_next           = ptr_reg;
    ol_next            = ol_reg;
    count_latched_next = count_latched_reg;
    data_out_next      = data_out_reg;
    read_clears        = 1'b0;
    if (bus.cw_write) begin
      ptr_next           = PTR_LSB;
      count_latched_next = 1'b0;
      ol_next            = count_value;
    end else begin
      if (!count_latched_reg) begin
        ol_next = count_value;
      end
      if (status_read) begin
        data_out_next = status_byte_q;
      end else if (bus.rd_strobe) begin
        case (rw)
          2'b01: begin
            data_out_next = ol_byte[0];
            read_clears   = 1'b1;
          end
          2'b10: begin
            data_out_next = ol_byte[1];
            read_clears   = 1'b1;
          end
          2'b11: begin
            if (ptr_reg == PTR_LSB) begin
              data_out_next = ol_byte[0];
              ptr_next      = PTR_MSB;
            end else begin
              data_out_next = ol_byte[1];
              ptr_next      = PTR_LSB;
              read_clears   = 1'b1;
            end
          end
          default: data_out_next = IDLE_DATA;
        endcase
      end
      if (read_clears) begin
        count_latched_next = 1'b0;
      end
      // A latch arriving with the read that releases the old latch re-arms it on the new count.
      if (latch_req && (!count_latched_reg || read_clears)) begin
        ol_next            = count_value;
        count_latched_next = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ptr_reg           <= PTR_LSB;
      ol_reg            <= '0;
      count_latched_reg <= 1'b0;
      data_out_reg      <= IDLE_DATA;
    end else begin
      ptr_reg           <= ptr_next;
      ol_reg            <= ol_next;
      count_latched_reg <= count_latched_next;
      data_out_reg      <= data_out_next;
    end
  end

  assign bus.data_out       = data_out_reg;
  assign bus.count_latched  = count_latched_reg;
  assign bus.status_latched = status_latched_q;

endmodule

// File: tb/tb_counter_read_latch.sv
// Bench for counter_read_latch: directed cases plus random traffic against a behavioural model.
`timescale 1ns/1ps
module tb_counter_read_latch;

`ifdef READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  cw;
  logic [15:0] cnt;
  logic        out_pin;
  logic        nc;

  counter_read_latch_if bif ();

  counter_read_latch dut (
    .CLK          (clk),
    .RESET        (rst),
    .control_word (cw),
    .count_value  (cnt),
    .OUT          (out_pin),
    .null_count   (nc),
    .bus          (bif)
  );

  always #5 clk = ~clk;

  int test_cnt = 0;
  int fail_cnt = 0;

  // Behavioural model state
  logic [15:0] m_ol;
  bit          m_cl;
  bit          m_sl;
  bit          m_msb_next;
  logic [7:0]  m_sb;
  logic [7:0]  m_dout;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    test_cnt++;
    assert (obs === exp)
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ol       = 16'h0000;
    m_cl       = 1'b0;
    m_sl       = 1'b0;
    m_msb_next = 1'b0;
    m_sb       = 8'h00;
    m_dout     = 8'h00;
  endtask

  task automatic model_clock(input bit cw_w, input bit lc, input bit rbc, input bit rbs, input bit rd);
    bit          rb_c, rb_s, frees, was_latched, had_status;
    logic [15:0] prev_ol;
    rb_c = RB && rbc;
    rb_s = RB && rbs;
    if (cw_w) begin
      m_cl       = 1'b0;
      m_sl       = 1'b0;
      m_msb_next = 1'b0;
      m_ol       = cnt;
      return;
    end
    prev_ol     = m_ol;
    was_latched = m_cl;
    had_status  = m_sl;
    frees       = 1'b0;
    if (rd) begin
      if (had_status) begin
        m_dout = m_sb;
        m_sl   = 1'b0;
      end else begin
        case (cw[5:4])
          2'b01: begin m_dout = prev_ol[7:0];  frees = 1'b1; end
          2'b10: begin m_dout = prev_ol[15:8]; frees = 1'b1; end
          2'b11: begin
            if (!m_msb_next) begin
              m_dout     = prev_ol[7:0];
              m_msb_next = 1'b1;
            end else begin
              m_dout     = prev_ol[15:8];
              m_msb_next = 1'b0;
              frees      = 1'b1;
            end
          end
          default: m_dout = 8'h00;
        endcase
      end
    end
    if (!was_latched) m_ol = cnt;
    if (frees) m_cl = 1'b0;
    if ((lc || rb_c) && (!was_latched || frees)) begin
      m_ol = cnt;
      m_cl = 1'b1;
    end
    if (rb_s && !had_status) begin
      m_sb = {out_pin, nc, cw};
      m_sl = 1'b1;
    end
  endtask

  task automatic cyc(input bit cw_w, input bit lc, input bit rbc, input bit rbs, input bit rd);
    bif.cw_write  = cw_w;
    bif.latch_cmd = lc;
    bif.rb_count  = rbc;
    bif.rb_status = rbs;
    bif.rd_strobe = rd;
    @(posedge clk);
    #1;
    model_clock(cw_w, lc, rbc, rbs, rd);
    bif.cw_write  = 1'b0;
    bif.latch_cmd = 1'b0;
    bif.rb_count  = 1'b0;
    bif.rb_status = 1'b0;
    bif.rd_strobe = 1'b0;
    chk("model_data_out", {8'h00, bif.data_out}, {8'h00, m_dout});
    chk("model_count_latched", {15'h0, bif.count_latched}, {15'h0, m_cl});
    chk("model_status_latched", {15'h0, bif.status_latched}, {15'h0, m_sl});
    if (rd) $display("[TB] read rw=%b data_out=%h count_latched=%b status_latched=%b",
                     cw[5:4], bif.data_out, bif.count_latched, bif.status_latched);
  endtask

  initial begin
    rst = 1'b1; cw = 6'h00; cnt = 16'h0000; out_pin = 1'b0; nc = 1'b0;
    bif.cw_write = 1'b0; bif.latch_cmd = 1'b0; bif.rb_count = 1'b0;
    bif.rb_status = 1'b0; bif.rd_strobe = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data_out", {8'h00, bif.data_out}, 16'h0000);
    chk("reset_count_latched", {15'h0, bif.count_latched}, 16'h0000);
    chk("reset_status_latched", {15'h0, bif.status_latched}, 16'h0000);
    rst = 1'b0;

    // RW=11 latched two-byte read
    cw = 6'b11_000_0; cyc(1, 0, 0, 0, 0);
    cnt = 16'h1234;   cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cnt = 16'h1200;
    chk("t1_latched", {15'h0, bif.count_latched}, 16'h0001);
    cyc(0, 0, 0, 0, 1);
    chk("t1_lsb", {8'h00, bif.data_out}, 16'h0034);
    chk("t1_latched_after_lsb", {15'h0, bif.count_latched}, 16'h0001);
    cyc(0, 0, 0, 0, 1);
    chk("t1_msb", {8'h00, bif.data_out}, 16'h0012);
    chk("t1_released", {15'h0, bif.count_latched}, 16'h0000);

    // Second latch while latched is ignored
    cnt = 16'hABCD; cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cnt = 16'h0001; cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t2_lsb", {8'h00, bif.data_out}, 16'h00CD);
    cyc(0, 0, 0, 0, 1);
    chk("t2_msb", {8'h00, bif.data_out}, 16'h00AB);

`ifdef READBACK_EN
    // Read-back of status and count together
    cw = 6'b11_010_0; cyc(1, 0, 0, 0, 0);
    out_pin = 1'b1; nc = 1'b0; cnt = 16'h0502; cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    chk("t3_status_latched", {15'h0, bif.status_latched}, 16'h0001);
    cyc(0, 0, 0, 0, 1);
    chk("t3_status", {8'h00, bif.data_out}, 16'h00B4);
    cyc(0, 0, 0, 0, 1);
    chk("t3_lsb", {8'h00, bif.data_out}, 16'h0002);
    cyc(0, 0, 0, 0, 1);
    chk("t3_msb", {8'h00, bif.data_out}, 16'h0005);
`else
    // Read-back ignored without the feature
    cw = 6'b01_000_0; cyc(1, 0, 0, 0, 0);
    cnt = 16'h0042; cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("t6_status_idle", {15'h0, bif.status_latched}, 16'h0000);
    cyc(0, 0, 0, 0, 1);
    chk("t6_data", {8'h00, bif.data_out}, 16'h0042);
    chk("t6_status_still_idle", {15'h0, bif.status_latched}, 16'h0000);
`endif

    // cw_write resets byte pointer mid-sequence
    cw = 6'b11_000_0; cyc(1, 0, 0, 0, 0);
    cnt = 16'h5566; cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t4_first_lsb", {8'h00, bif.data_out}, 16'h0066);
    cnt = 16'h7788; cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t4_lsb_after_cw", {8'h00, bif.data_out}, 16'h0088);

    // Latch and read in the same cycle, RW=01
    cw = 6'b01_000_0; cyc(1, 0, 0, 0, 0);
    cnt = 16'h00FF; cyc(0, 0, 0, 0, 0);
    cnt = 16'h0011; cyc(0, 1, 0, 0, 1);
    chk("t5_pre_latch_data", {8'h00, bif.data_out}, 16'h00FF);
    chk("t5_latched", {15'h0, bif.count_latched}, 16'h0001);
    cnt = 16'h0033; cyc(0, 0, 0, 0, 1);
    chk("t5_new_ol", {8'h00, bif.data_out}, 16'h0011);

    // cw_write discards same-cycle latch and read
    cyc(1, 1, 0, 0, 1);
    chk("cw_discard_data", {8'h00, bif.data_out}, 16'h0011);
    chk("cw_discard_latch", {15'h0, bif.count_latched}, 16'h0000);

    // RW=00 reads return idle data
    cw = 6'b00_000_0; cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("rw00_idle", {8'h00, bif.data_out}, 16'h0000);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit cw_w;
      cnt     = 16'($urandom);
      out_pin = 1'($urandom);
      nc      = 1'($urandom);
      cw_w    = ($urandom_range(0, 15) == 0);
      if (cw_w) cw = 6'($urandom);
      cyc(cw_w, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1);
    end

    // Asynchronous reset while latched
    cw = 6'b01_000_0; cyc(1, 0, 0, 0, 0);
    cnt = 16'h12AB; cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("rst_pre_data", {8'h00, bif.data_out}, 16'h00AB);
    cyc(0, 1, 0, 0, 0);
    chk("rst_pre_latched", {15'h0, bif.count_latched}, 16'h0001);
    rst = 1'b1;
    #1;
    chk("rst_async_latched", {15'h0, bif.count_latched}, 16'h0000);
    chk("rst_async_data", {8'h00, bif.data_out}, 16'h0000);
    chk("rst_async_status", {15'h0, bif.status_latched}, 16'h0000);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cnt = 16'h0077; cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("post_rst_read", {8'h00, bif.data_out}, 16'h0077);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
